divu_hilo: RTL and testbench
============================

# divu_hilo

Sequential unsigned 32-bit divider with its own Hi/Lo result registers. It is the responder for the DIVU / MFHI / MFLO function codes the ALU stimulus bench issues. It sits beside the combinational ALU datapath inside the top-level ALU and shares its `dataA`/`dataB`/`signal`/`dataOut` interface. It computes quotient and remainder one bit per cycle and serves them back on MFLO/MFHI.

## Interface
- `WIDTH`, 32: operand, quotient and remainder width.
- `OP_DIVU`, 6'd27: function code that starts a division.
- `OP_MFHI`, 6'd16: function code that reads Hi (remainder).
- `OP_MFLO`, 6'd18: function code that reads Lo (quotient).

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dataA`  in  WIDTH  dividend, sampled at start.
- `dataB`  in  WIDTH  divisor, sampled at start.
- `signal`  in  6  function code.
- `dataOut`  out  WIDTH  Hi on MFHI, Lo on MFLO, 0 otherwise.
- `busy`  out  1  high while iterating.
- `done`  out  1  high in DONE state.

## Operation
- States:
  - IDLE: start when `signal==OP_DIVU`. Capture A and B, rem=0, quo=A, cnt=0, then go to BUSY.
  - BUSY: one restoring step per cycle. {rem,quo} shifts left 1. If the shifted rem ≥ B, rem -= B and quo[0]=1. cnt++. After the step with cnt==WIDTH-1, write hi=rem and lo=quo, then go to DONE.
  - DONE: stay while `signal==OP_DIVU`. Go to IDLE otherwise.
- A held DIVU code never restarts a division. A new division needs `signal` to leave OP_DIVU, or a reset.
- Divide by zero: no special case in the datapath. The restoring steps naturally yield lo=all-ones and hi=dividend. This behaviour is mandatory.
- Changing `signal` away from OP_DIVU during BUSY does not abort the division. It completes, and the FSM passes through DONE to IDLE on the next cycle.
- `dataOut` is a combinational mux of hi/lo selected by `signal`. MFHI/MFLO during BUSY return the previous hi/lo values.
- The rem datapath is WIDTH+1 bits wide for the compare/subtract. No overflow is possible.

## Timing
- Reset (asynchronous, `reset`=0):
  - state=IDLE; hi=lo=0; rem/quo/cnt=0.
  - `busy`=0, `done`=0, `dataOut`=0 for non-read codes.
- A reset mid-division aborts it and clears hi/lo immediately.
- Latency: start is sampled at edge E0. BUSY spans edges E1..E32. hi/lo are written and DONE is entered at edge E32. Results are visible on `dataOut` from E32 plus combinational delay, which is within the 35-cycle bench window.
- `busy` is high from after E0 through E32. `done` is high from E32 until the first edge that samples `signal≠OP_DIVU`.
- MFHI/MFLO reads have zero-cycle latency and are valid in the same cycle the code is applied.

## Configuration
- `DIVU_DBZ_FAST_EN`: adds output port `dbz` (1 bit).
  - Behaviour with the macro: B==0 at start goes IDLE→DONE in one cycle. hi=dividend, lo=all-ones, `dbz`=1 until the next start or reset. `busy` never asserts for that division.
  - Behaviour without the macro: no `dbz` port, and divide by zero runs the full 32 steps with the same hi/lo result.

## Test plan
- Basic divide: reset, DIVU A=100, B=7, hold 35 cycles → MFHI `dataOut`=2, MFLO `dataOut`=14; `done`=1 at E32.
- Edge operands: A=32'hFFFFFFFF, B=1 → lo=32'hFFFFFFFF, hi=0. Then A=5, B=9 → lo=0, hi=5.
- Divide by zero: A=1234, B=0 → lo=32'hFFFFFFFF, hi=1234.
  - With `DIVU_DBZ_FAST_EN`: `done` at E1 and `dbz`=1.
  - Without the macro: `done` at E32.
- Held start: keep `signal`=27 for 80 cycles after one division → exactly one BUSY period and `busy` never re-asserts. Changing A/B during hold has no effect on hi/lo.
- Read during busy: complete 100/7, then start 50/3 and apply MFLO at E10 → `dataOut`=14 (old). After completion, MFLO → 16 and MFHI → 2.
- Reset mid-op: start 1000/3 and drive `reset` low at E15 → hi=lo=0, state IDLE, `busy`=0 immediately without a clock edge. A new DIVU 9/2 afterwards → lo=4, hi=1.

Source files
------------

// File: rtl/divu_hilo.sv
// divu_hilo -- sequential unsigned divider with private Hi/Lo result registers.
//
// Restoring division, one quotient bit per clock. A DIVU function code seen in
// IDLE captures the operands; WIDTH cycles later the remainder lands in Hi and
// the quotient in Lo. MFHI/MFLO read them back combinationally on dataOut.
// A DIVU code that is held does not start another division. The code must
// leave OP_DIVU first.
//
// Optional feature macro: DIVU_DBZ_FAST_EN
//   When defined, a zero divisor skips the iteration. The divider finishes one
//   cycle after start with hi=dividend and lo=all-ones, busy stays low, and
//   the extra output dbz flags the event until the next start or reset.
//
// Ports:
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous active-low reset
//   dataA   in   WIDTH  dividend, sampled at start
//   dataB   in   WIDTH  divisor, sampled at start
//   signal  in   6      function code (DIVU starts, MFHI/MFLO read)
//   dataOut out  WIDTH  hi on MFHI, lo on MFLO, zero otherwise
//   busy    out  1      high while iterating
//   done    out  1      high in DONE
//   dbz     out  1      divide-by-zero flag (only with DIVU_DBZ_FAST_EN)

`timescale 1ns/1ps

module divu_hilo #(
  parameter int             WIDTH   = 32,
  parameter logic [5:0]     OP_DIVU = 6'd27,
  parameter logic [5:0]     OP_MFHI = 6'd16,
  parameter logic [5:0]     OP_MFLO = 6'd18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       signal,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
`ifdef DIVU_DBZ_FAST_EN
  ,
  output logic             dbz
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [2*WIDTH-1:0] step_s;
`ifdef DIVU_DBZ_FAST_EN
  logic             dbz_r;
`endif

  // One restoring step: shift {rem,quo} left, subtract the divisor when it fits.
  // The shifted remainder needs WIDTH+1 bits for the compare. When the
  // subtraction happens, the result is below the divisor, so the low WIDTH bits
  // of a modular subtract are exact.
  function automatic logic [2*WIDTH-1:0] divstep(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] df;
    sh = {rem, quo[WIDTH-1]};
    df = sh[WIDTH-1:0] - dvs;
    if (sh >= {1'b0, dvs}) begin
      divstep = {df, quo[WIDTH-2:0], 1'b1};
    end else begin
      divstep = {sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    end
  endfunction

  // Next {rem,quo} for the current iteration.
  always_comb begin
    step_s = divstep(rem_r, quo_r, div_r);
  end

  // Divider FSM with operand, iteration and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      rem_r   <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      div_r   <= {WIDTH{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef DIVU_DBZ_FAST_EN
      dbz_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (signal == OP_DIVU) begin
            div_r   <= dataB;
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= dataA;
            cnt_r   <= {CW{1'b0}};
            state_r <= ST_BUSY;
`ifdef DIVU_DBZ_FAST_EN
            // A zero divisor takes the one-cycle shortcut through BUSY without
            // ever raising busy.
            busy_r  <= (dataB != {WIDTH{1'b0}});
            dbz_r   <= 1'b0;
`else
            busy_r  <= 1'b1;
`endif
          end
        end
        ST_BUSY: begin
`ifdef DIVU_DBZ_FAST_EN
          if (div_r == {WIDTH{1'b0}}) begin
            // quo_r still holds the untouched dividend here.
            hi_r    <= quo_r;
            lo_r    <= {WIDTH{1'b1}};
            dbz_r   <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
`endif
            rem_r <= step_s[2*WIDTH-1:WIDTH];
            quo_r <= step_s[WIDTH-1:0];
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == CW'(WIDTH - 1)) begin
              hi_r    <= step_s[2*WIDTH-1:WIDTH];
              lo_r    <= step_s[WIDTH-1:0];
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
`ifdef DIVU_DBZ_FAST_EN
          end
`endif
        end
        ST_DONE: begin
          // A held DIVU parks here, so the divider cannot restart itself.
          if (signal != OP_DIVU) begin
            done_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Read mux: Hi/Lo reads are combinational, so they are valid in the same cycle.
  always_comb begin
    dataOut = {WIDTH{1'b0}};
    case (signal)
      OP_MFHI: dataOut = hi_r;
      OP_MFLO: dataOut = lo_r;
      default: dataOut = {WIDTH{1'b0}};
    endcase
  end

  assign busy = busy_r;
  assign done = done_r;
`ifdef DIVU_DBZ_FAST_EN
  assign dbz  = dbz_r;
`endif

endmodule

// File: tb/tb_divu_hilo.sv
// tb_divu_hilo -- directed self-checking bench for divu_hilo.
// Expected Hi/Lo pairs are pushed to a scoreboard queue when a division is
// started and popped when the results are read back through MFLO/MFHI.
// Latency is counted in clock edges after the start edge E0.

`timescale 1ns/1ps

module tb_divu_hilo;

  localparam logic [5:0] OP_DIVU = 6'd27;
  localparam logic [5:0] OP_MFHI = 6'd16;
  localparam logic [5:0] OP_MFLO = 6'd18;
  localparam logic [5:0] OP_NONE = 6'd0;

  logic        clk;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  signal;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;
`ifdef DIVU_DBZ_FAST_EN
  logic        dbz;
`endif

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  logic [63:0] sb_q[$];

  divu_hilo dut (
    .clk     (clk),
    .reset   (reset),
    .dataA   (dataA),
    .dataB   (dataB),
    .signal  (signal),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
`ifdef DIVU_DBZ_FAST_EN
    ,
    .dbz     (dbz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  // Drive a DIVU start at a negedge and record the expected {hi,lo}.
  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh;
    logic [31:0] el;
    @(negedge clk);
    dataA  = a;
    dataB  = b;
    signal = OP_DIVU;
    if (b == 32'd0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else begin
      eh = a % b;
      el = a / b;
    end
    sb_q.push_back({eh, el});
    edge_cnt = -1;
  endtask

  // Wait (bounded) for done and check the edge count after E0.
  task automatic wait_done(input string tag, input int exp_lat);
    int guard;
    guard = 0;
    while (!done && guard < 60) begin
      step_edge();
      guard++;
    end
    chk(tag, 32'(edge_cnt), 32'(exp_lat));
  endtask

  // Pop the expected pair and compare it with MFLO and MFHI reads.
  // Then park signal for one edge so that DONE returns to IDLE.
  task automatic read_check(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      e = 64'd0;
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
    end
    signal = OP_MFLO;
    #1;
    chk({tag, "_lo"}, dataOut, e[31:0]);
    signal = OP_MFHI;
    #1;
    chk({tag, "_hi"}, dataOut, e[63:32]);
    signal = OP_NONE;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic busy_seen;
    logic [63:0] dropped;
    reset  = 1'b0;
    dataA  = 32'd0;
    dataB  = 32'd0;
    signal = OP_NONE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    signal = OP_MFLO;
    #1;
    chk("rst_lo", dataOut, 32'd0);
    signal = OP_NONE;
    @(negedge clk);
    reset = 1'b1;

    // Basic 100/7 with DIVU held through completion and then for 80 more cycles.
    start_div(32'd100, 32'd7);
    step_edge();
    chk("basic_busy_e0", {31'd0, busy}, 32'd1);
    wait_done("basic_lat", 32);
    busy_seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i == 40) begin
        dataA = 32'd999;
        dataB = 32'd5;
      end
      step_edge();
      if (busy) busy_seen = 1'b1;
    end
    chk("held_no_busy", {31'd0, busy_seen}, 32'd0);
    chk("held_done", {31'd0, done}, 32'd1);
    read_check("basic");

    // Read during busy: old lo (14) is still served while 50/3 iterates.
    start_div(32'd50, 32'd3);
    repeat (11) step_edge();
    #4;
    signal = OP_MFLO;
    #1;
    chk("busyrd_old_lo", dataOut, 32'd14);
    chk("busyrd_busy", {31'd0, busy}, 32'd1);
    wait_done("busyrd_lat", 32);
    read_check("busyrd");

    // Edge operands.
    start_div(32'hFFFF_FFFF, 32'd1);
    wait_done("max_lat", 32);
    read_check("max_div1");
    start_div(32'd5, 32'd9);
    wait_done("small_lat", 32);
    read_check("small");

    // Divide by zero.
    start_div(32'd1234, 32'd0);
`ifdef DIVU_DBZ_FAST_EN
    wait_done("dbz_lat", 1);
    chk("dbz_flag", {31'd0, dbz}, 32'd1);
`else
    wait_done("dbz_lat", 32);
`endif
    read_check("dbz");

    // Reset mid-operation clears everything without a clock edge.
    start_div(32'd1000, 32'd3);
    repeat (16) step_edge();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    signal = OP_MFLO;
    #1;
    chk("midrst_lo", dataOut, 32'd0);
    signal = OP_MFHI;
    #1;
    chk("midrst_hi", dataOut, 32'd0);
    signal = OP_NONE;
    if (sb_q.size() != 0) dropped = sb_q.pop_front();
    @(negedge clk);
    reset = 1'b1;
    start_div(32'd9, 32'd2);
    wait_done("post_rst_lat", 32);
    read_check("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
